// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, status/ctrl bit indices and FSM state types for apb_uart_fifo
package uart_pkg;

    localparam logic [4:0] DATA_OFS   = 5'h00;
    localparam logic [4:0] STATUS_OFS = 5'h04;
    localparam logic [4:0] BAUD_OFS   = 5'h08;
    localparam logic [4:0] CTRL_OFS   = 5'h0C;

    localparam int ST_TXRDY       = 0;
    localparam int ST_RXRDY       = 1;
    localparam int ST_PARITY_ERR  = 2;
    localparam int ST_OVERFLOW    = 3;
    localparam int ST_FRAMING_ERR = 4;
    localparam int ST_TX_IDLE     = 5;

    localparam int CTRL_PAR_EN   = 0;
    localparam int CTRL_PAR_ODD  = 1;
    localparam int CTRL_LOOPBACK = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        TXS_IDLE,
        TXS_START,
        TXS_DATA,
        TXS_PARITY,
        TXS_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RXS_IDLE,
        RXS_START,
        RXS_DATA,
        RXS_PARITY,
        RXS_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with extra-MSB pointers; a push into a full FIFO succeeds only alongside a pop
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// rtl/apb_uart_fifo.sv - APB UART with programmable baud/parity and TX/RX FIFOs
// Optional internal loopback via CTRL bit2 when UART_LOOPBACK_EN is defined.
module apb_uart_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16,
    parameter int BAUD_RESET = 1,
    parameter int APB_AW     = 5
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [APB_AW-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              RX,
    output logic              TX,
    output logic              TXRDY,
    output logic              RXRDY,
    output logic              PARITY_ERR,
    output logic              OVERFLOW,
    output logic              FRAMING_ERR
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] MID_TICK  = CW'(MID_SAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_WIDTH - 1);
`ifdef UART_LOOPBACK_EN
    localparam int CTRL_W = 3;
`else
    localparam int CTRL_W = 2;
`endif

    logic [15:0]           baud;
    logic [CTRL_W-1:0]     ctrl;
    logic [15:0]           baud_cnt;
    logic                  tick;
    logic                  par_en, par_odd;
    logic                  access, sel_data, sel_status, sel_baud, sel_ctrl, mapped;
    logic [4:0]            ofs;
    logic                  tx_push_req, rx_pop_req, rx_pop, status_clr;
    logic                  tx_full, tx_empty, tx_pop;
    logic                  rx_full, rx_empty, rx_done;
    logic [DATA_WIDTH-1:0] tx_rdata, rx_rdata;
    logic                  pe_flag, ov_flag, fe_flag, tx_idle;
    logic [5:0]            status;
    logic                  unused_bits;

    assign access     = PSEL & PENABLE;
    assign ofs        = {PADDR[4:2], 2'b00};
    assign sel_data   = (ofs == DATA_OFS);
    assign sel_status = (ofs == STATUS_OFS);
    assign sel_baud   = (ofs == BAUD_OFS);
    assign sel_ctrl   = (ofs == CTRL_OFS);
    assign mapped     = sel_data | sel_status | sel_baud | sel_ctrl;
    assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};

    assign tx_push_req = access & PWRITE & sel_data;
    assign rx_pop_req  = access & ~PWRITE & sel_data;
    assign rx_pop      = rx_pop_req & ~rx_empty;
    assign status_clr  = access & PWRITE & sel_status;
    assign PREADY      = 1'b1;
    assign PSLVERR     = access & (~mapped | (tx_push_req & tx_full) | (rx_pop_req & rx_empty));

    assign par_en  = ctrl[CTRL_PAR_EN];
    assign par_odd = ctrl[CTRL_PAR_ODD];

    assign status = {tx_idle, fe_flag, ov_flag, pe_flag, ~rx_empty, ~tx_full};

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (ofs)
                DATA_OFS:   if (!rx_empty) PRDATA[DATA_WIDTH-1:0] = rx_rdata;
                STATUS_OFS: PRDATA[5:0] = status;
                BAUD_OFS:   PRDATA[15:0] = baud;
                CTRL_OFS:   PRDATA[CTRL_W-1:0] = ctrl;
                default:    PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            baud <= 16'(BAUD_RESET);
            ctrl <= '0;
        end else if (access && PWRITE) begin
            if (sel_baud) baud <= PWDATA[15:0];
            if (sel_ctrl) ctrl <= PWDATA[CTRL_W-1:0];
        end
    end

    // Reload on tick only, so a BAUD write lands at the next period boundary.
    assign tick = (baud_cnt == 16'd0);
    always_ff @(posedge PCLK) begin
        if (PRESET)    baud_cnt <= '0;
        else if (tick) baud_cnt <= baud;
        else           baud_cnt <= baud_cnt - 1'b1;
    end

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(PCLK), .reset(PRESET),
        .push(tx_push_req & ~tx_full), .wdata(PWDATA[DATA_WIDTH-1:0]),
        .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
    );

    // ---------------- transmitter ----------------
    tx_state_t             tx_state, tx_state_n;
    logic [CW-1:0]         tx_tick_cnt;
    logic [3:0]            tx_bit_cnt;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_par, tx_bit_end, tx_serial;

    assign tx_bit_end = tick && (tx_tick_cnt == LAST_TICK);
    assign tx_idle    = tx_empty && (tx_state == TXS_IDLE);

    always_comb begin
        tx_state_n = tx_state;
        tx_pop     = 1'b0;
        case (tx_state)
            TXS_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_state_n = TXS_START;
            end
            TXS_START:  if (tx_bit_end) tx_state_n = TXS_DATA;
            TXS_DATA:   if (tx_bit_end && tx_bit_cnt == LAST_BIT)
                            tx_state_n = par_en ? TXS_PARITY : TXS_STOP;
            TXS_PARITY: if (tx_bit_end) tx_state_n = TXS_STOP;
            TXS_STOP:   if (tx_bit_end) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_n = TXS_START;
                end else begin
                    tx_state_n = TXS_IDLE;
                end
            end
            default: tx_state_n = TXS_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tx_state    <= TXS_IDLE;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_state == TXS_IDLE) tx_tick_cnt <= '0;
            else if (tick)            tx_tick_cnt <= tx_tick_cnt + 1'b1;
            if (tx_pop) begin
                tx_shift   <= tx_rdata;
                tx_par     <= ^tx_rdata ^ par_odd;
                tx_bit_cnt <= '0;
            end else if (tx_state == TXS_DATA && tx_bit_end) begin
                tx_shift   <= tx_shift >> 1;
                tx_bit_cnt <= tx_bit_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        case (tx_state)
            TXS_START:  tx_serial = 1'b0;
            TXS_DATA:   tx_serial = tx_shift[0];
            TXS_PARITY: tx_serial = tx_par;
            default:    tx_serial = 1'b1;
        endcase
    end

    // ---------------- receiver ----------------
    rx_state_t             rx_state, rx_state_n;
    logic                  rx_meta, rx_sync, rx_in, rx_prev;
    logic [CW-1:0]         rx_tick_cnt;
    logic [3:0]            rx_bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_par_bad, rx_sample;

`ifdef UART_LOOPBACK_EN
    logic loopback;
    assign loopback = ctrl[CTRL_LOOPBACK];
    assign rx_in    = loopback ? tx_serial : rx_sync;
    assign TX       = loopback ? 1'b1 : tx_serial;
`else
    assign rx_in = rx_sync;
    assign TX    = tx_serial;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_in;
        end
    end

    // Tick counter starts at the falling edge, so MID_TICK lands mid-bit for every bit.
    assign rx_sample = tick && (rx_tick_cnt == MID_TICK);

    always_comb begin
        rx_state_n = rx_state;
        rx_done    = 1'b0;
        case (rx_state)
            RXS_IDLE:   if (rx_prev && !rx_in) rx_state_n = RXS_START;
            RXS_START:  if (rx_sample) rx_state_n = rx_in ? RXS_IDLE : RXS_DATA;
            RXS_DATA:   if (rx_sample && rx_bit_cnt == LAST_BIT)
                            rx_state_n = par_en ? RXS_PARITY : RXS_STOP;
            RXS_PARITY: if (rx_sample) rx_state_n = RXS_STOP;
            RXS_STOP:   if (rx_sample) begin
                rx_done    = 1'b1;
                rx_state_n = RXS_IDLE;
            end
            default: rx_state_n = RXS_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rx_state    <= RXS_IDLE;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_par_bad  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            if (rx_state == RXS_IDLE) begin
                rx_tick_cnt <= '0;
                rx_bit_cnt  <= '0;
                rx_par_bad  <= 1'b0;
            end else begin
                if (tick) rx_tick_cnt <= rx_tick_cnt + 1'b1;
                if (rx_state == RXS_DATA && rx_sample) begin
                    rx_shift   <= {rx_in, rx_shift[DATA_WIDTH-1:1]};
                    rx_bit_cnt <= rx_bit_cnt + 1'b1;
                end
                if (rx_state == RXS_PARITY && rx_sample)
                    rx_par_bad <= rx_in ^ (^rx_shift) ^ par_odd;
            end
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(PCLK), .reset(PRESET),
        .push(rx_done), .wdata(rx_shift),
        .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
    );

    // Set beats a same-cycle write-1-clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pe_flag <= 1'b0;
            ov_flag <= 1'b0;
            fe_flag <= 1'b0;
        end else begin
            pe_flag <= (rx_done & rx_par_bad) |
                       (pe_flag & ~(status_clr & PWDATA[ST_PARITY_ERR]));
            ov_flag <= (rx_done & rx_full & ~rx_pop) |
                       (ov_flag & ~(status_clr & PWDATA[ST_OVERFLOW]));
            fe_flag <= (rx_done & ~rx_in) |
                       (fe_flag & ~(status_clr & PWDATA[ST_FRAMING_ERR]));
        end
    end

    assign TXRDY       = ~tx_full;
    assign RXRDY       = ~rx_empty;
    assign PARITY_ERR  = pe_flag;
    assign OVERFLOW    = ov_flag;
    assign FRAMING_ERR = fe_flag;

endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb/tb_apb_uart_fifo.sv - directed scoreboard bench for apb_uart_fifo (loopback step when UART_LOOPBACK_EN is defined)
module tb_apb_uart_fifo;

    localparam int BITC = 16;

    logic        PCLK = 1'b0;
    logic        PRESET, PSEL, PENABLE, PWRITE, RX;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, TX, TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    always #5 PCLK = ~PCLK;

    apb_uart_fifo #(.DATA_WIDTH(8), .TX_DEPTH(16), .RX_DEPTH(16), .BAUD_RESET(1), .APB_AW(5)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .RX(RX), .TX(TX), .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR),
        .OVERFLOW(OVERFLOW), .FRAMING_ERR(FRAMING_ERR)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wdata, output logic err);
        logic [31:0] dummy;
        apb(1'b1, addr, wdata, dummy, err);
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] rdata, output logic err);
        apb(1'b0, addr, 32'h0, rdata, err);
    endtask

    task automatic drive_bit(input logic b);
        @(negedge PCLK);
        RX = b;
        repeat (BITC - 1) @(negedge PCLK);
    endtask

    task automatic send_rx(input logic [7:0] d, input bit use_par, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (use_par) drive_bit(par);
        drive_bit(stop);
        @(negedge PCLK);
        RX = 1'b1;
        repeat (BITC) @(negedge PCLK);
    endtask

    task automatic tx_decode(input int limit, input bit use_par, output logic found,
                             output logic st, output logic [7:0] d, output logic p, output logic sp);
        int n;
        n = 0; found = 1'b0; st = 1'b1; d = '0; p = 1'b0; sp = 1'b0;
        while (TX !== 1'b0 && n < limit) begin
            @(negedge PCLK);
            n++;
        end
        if (TX === 1'b0) begin
            found = 1'b1;
            repeat (BITC / 2) @(negedge PCLK);
            st = TX;
            for (int i = 0; i < 8; i++) begin
                repeat (BITC) @(negedge PCLK);
                d[i] = TX;
            end
            if (use_par) begin
                repeat (BITC) @(negedge PCLK);
                p = TX;
            end
            repeat (BITC) @(negedge PCLK);
            sp = TX;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic        e, found, st, p, sp;
        logic [7:0]  d, exp_byte;
        int          nerr, nlow;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; RX = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        // reset state
        check("rst_tx", TX, 1'b1);
        check("rst_txrdy", TXRDY, 1'b1);
        check("rst_rxrdy", RXRDY, 1'b0);
        check("rst_prdata_idle", PRDATA, 32'h0);
        rd(5'h04, r, e); check("rst_status", r, 32'h21);
        rd(5'h08, r, e); check("rst_baud", r, 32'h1);

        // single TX frame, no parity, 16 clocks per bit
        wr(5'h08, 32'h0, e);
        wr(5'h0C, 32'h0, e);
        wr(5'h00, 32'hA5, e); tx_exp.push_back(8'hA5);
        check("tx_a5_err", e, 1'b0);
        tx_decode(100, 1'b0, found, st, d, p, sp);
        check("tx_a5_found", found, 1'b1);
        check("tx_a5_start", st, 1'b0);
        check("tx_a5_data", d, tx_exp.pop_front());
        check("tx_a5_stop", sp, 1'b1);
        rd(5'h04, r, e); check("tx_busy_at_stop", r[5], 1'b0);
        repeat (10) @(negedge PCLK);
        rd(5'h04, r, e); check("tx_idle_after", r[5], 1'b1);

        // TX with even parity
        wr(5'h0C, 32'h1, e);
        wr(5'h00, 32'h07, e); tx_exp.push_back(8'h07);
        tx_decode(100, 1'b1, found, st, d, p, sp);
        exp_byte = tx_exp.pop_front();
        check("tx_par_data", d, exp_byte);
        check("tx_par_bit", p, ^exp_byte);
        check("tx_par_stop", sp, 1'b1);

        // RX with bad even parity, then a good one
        send_rx(8'h07, 1'b1, 1'b0, 1'b1); rx_exp.push_back(8'h07);
        check("rx_pe_rxrdy", RXRDY, 1'b1);
        check("rx_pe_flag_pin", PARITY_ERR, 1'b1);
        rd(5'h00, r, e); check("rx_pe_data", r, rx_exp.pop_front());
        rd(5'h04, r, e); check("rx_pe_status", r, 32'h25);
        wr(5'h04, 32'h04, e);
        rd(5'h04, r, e); check("rx_pe_cleared", r, 32'h21);
        send_rx(8'h03, 1'b1, 1'b0, 1'b1); rx_exp.push_back(8'h03);
        rd(5'h00, r, e); check("rx_goodpar_data", r, rx_exp.pop_front());
        rd(5'h04, r, e); check("rx_goodpar_status", r, 32'h21);

        // framing error: character still delivered
        wr(5'h0C, 32'h0, e);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0); rx_exp.push_back(8'h5A);
        rd(5'h00, r, e); check("rx_fe_data", r, rx_exp.pop_front());
        rd(5'h04, r, e); check("rx_fe_status", r, 32'h31);
        wr(5'h04, 32'h10, e);
        rd(5'h04, r, e); check("rx_fe_cleared", r, 32'h21);

        // TX FIFO fill at slow baud; first byte is all ones so its tail shows no edges
        wr(5'h08, 32'd100, e);
        rd(5'h08, r, e); check("baud_rw", r, 32'd100);
        nerr = 0;
        wr(5'h00, 32'hFF, e); if (e) nerr++;
        for (int i = 0; i < 16; i++) begin
            wr(5'h00, 32'h41 + i, e); if (e) nerr++;
            tx_exp.push_back(8'(8'h41 + i));
        end
        check("fill_no_err", nerr, 0);
        check("fill_txrdy", TXRDY, 1'b0);
        wr(5'h00, 32'hEE, e); check("full_write_err", e, 1'b1);
        rd(5'h1C, r, e); check("unmapped_err", e, 1'b1);
        wr(5'h08, 32'h0, e);
        nlow = 0;
        while (TX !== 1'b1 && nlow < 400) begin @(negedge PCLK); nlow++; end
        check("first_start_end", TX, 1'b1);
        for (int i = 0; i < 16; i++) begin
            tx_decode(400, 1'b0, found, st, d, p, sp);
            exp_byte = tx_exp.pop_front();
            check("drain_found", found, 1'b1);
            check("drain_data", d, exp_byte);
        end
        nlow = 0;
        repeat (300) begin @(negedge PCLK); if (TX !== 1'b1) nlow++; end
        check("dropped_byte_absent", nlow, 0);
        rd(5'h04, r, e); check("drain_status", r, 32'h21);

        // RX overflow: first 16 kept in order
        for (int i = 0; i < 17; i++) begin
            send_rx(8'(8'h30 + i), 1'b0, 1'b0, 1'b1);
            if (i < 16) rx_exp.push_back(8'(8'h30 + i));
        end
        rd(5'h04, r, e); check("ovf_status", r, 32'h2B);
        for (int i = 0; i < 16; i++) begin
            rd(5'h00, r, e);
            check("ovf_data", r, rx_exp.pop_front());
        end
        rd(5'h00, r, e);
        check("empty_read_err", e, 1'b1);
        check("empty_read_data", r, 32'h0);
        wr(5'h04, 32'h08, e);
        rd(5'h04, r, e); check("ovf_cleared", r, 32'h21);

        // short low glitch on RX is rejected
        @(negedge PCLK); RX = 1'b0;
        repeat (4) @(negedge PCLK);
        RX = 1'b1;
        repeat (60) @(negedge PCLK);
        check("glitch_rxrdy", RXRDY, 1'b0);
        rd(5'h04, r, e); check("glitch_status", r, 32'h21);

        // reset mid-frame
        wr(5'h00, 32'h00, e);
        repeat (40) @(negedge PCLK);
        check("midframe_tx_low", TX, 1'b0);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("midframe_rst_tx", TX, 1'b1);
        PRESET = 1'b0;
        rd(5'h04, r, e); check("midframe_rst_status", r, 32'h21);
        rd(5'h08, r, e); check("midframe_rst_baud", r, 32'h1);

`ifdef UART_LOOPBACK_EN
        wr(5'h08, 32'h0, e);
        wr(5'h0C, 32'h4, e);
        wr(5'h00, 32'h3C, e); rx_exp.push_back(8'h3C);
        nlow = 0;
        repeat (250) begin @(negedge PCLK); if (TX !== 1'b1) nlow++; end
        check("loop_tx_pin_high", nlow, 0);
        rd(5'h00, r, e); check("loop_data", r, rx_exp.pop_front());
`else
        wr(5'h0C, 32'h7, e);
        rd(5'h0C, r, e); check("ctrl_no_loopback", r, 32'h3);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
